// File: rtl/dmem_pkg.sv
// Shared types for the DataMemory access controller: access sizes,
// controller state encoding and the size-to-byte-count helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'b00,
        SIZE_WORD   = 2'b01,
        SIZE_DOUBLE = 2'b10,
        SIZE_RSVD   = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Number of bytes touched by an access; reserved size touches nothing.
    function automatic logic [3:0] size_bytes(input size_e s);
        case (s)
            SIZE_BYTE:   size_bytes = 4'd1;
            SIZE_WORD:   size_bytes = 4'd4;
            SIZE_DOUBLE: size_bytes = 4'd8;
            default:     size_bytes = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among pending requests, searching from
// the requester after the last one granted. The pointer moves only on advance.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] grant_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int unsigned   idx;

    // Pick the first pending request at or after the pointer, wrapping once.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            for (int unsigned j = 0; j < NREQ; j++) begin
                if (!found && (j == idx) && req_i[j]) begin
                    grant_o[j] = 1'b1;
                    found      = 1'b1;
                    ptr_d      = (j + 1 == NREQ) ? '0 : PW'(j + 1);
                end
            end
        end
    end

    // Search start pointer, updated only when a grant is actually taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequencing controller in front of the combinational big-endian DataMemory.
// Arbitrates NREQ requesters, runs one access at a time through
// IDLE -> ACCESS -> RESP, and pulses the memory write enables for exactly
// the single ACCESS cycle of a legal store.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int MEM_BYTES    = 1024,
    parameter bit STRICT_ALIGN = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [2*NREQ-1:0]    req_size,
    input  logic [32*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    input  logic [32*NREQ-1:0]   req_wdata2,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic [31:0]          rsp_rdata2,
    output logic                 rsp_err,
    output logic [31:0]          mem_address,
    output logic [31:0]          mem_in1,
    output logic [31:0]          mem_in2,
    output logic                 mem_byte,
    output logic                 mem_write,
    output logic                 mem_dwrite,
    input  logic [31:0]          mem_out1,
    input  logic [31:0]          mem_out2
);

    state_e          state_q;
    logic [NREQ-1:0] gnt, gnt_q;
    logic            adv;

    size_e           size_sel;
    logic            we_sel;
    logic [31:0]     addr_sel, wd_sel, wd2_sel;
    logic [32:0]     end_sel;
    logic            misalign, legal_sel;

    logic [31:0]     addr_q, in1_q, in2_q;
    logic            byte_q, dbl_q, legal_q;
    logic            mem_write_q, mem_dwrite_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [31:0]     rdata_q, rdata2_q;
    logic            err_q;

    assign adv = (state_q == IDLE) && (|req_valid);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req_valid),
        .advance_i (adv),
        .grant_o   (gnt)
    );

    // Route the granted requester's fields to the latch inputs.
    always_comb begin
        size_sel = SIZE_BYTE;
        we_sel   = 1'b0;
        addr_sel = '0;
        wd_sel   = '0;
        wd2_sel  = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (gnt[j]) begin
                size_sel = size_e'(req_size[2*j +: 2]);
                we_sel   = req_we[j];
                addr_sel = req_addr[32*j +: 32];
                wd_sel   = req_wdata[32*j +: 32];
                wd2_sel  = req_wdata2[32*j +: 32];
            end
        end
    end

    // Legality of the granted request; end address is 33 bits so it cannot wrap.
    always_comb begin
        end_sel  = {1'b0, addr_sel} + {29'b0, size_bytes(size_sel)};
        misalign = STRICT_ALIGN &&
                   (((size_sel == SIZE_WORD)   && (addr_sel[1:0] != 2'b00)) ||
                    ((size_sel == SIZE_DOUBLE) && (addr_sel[2:0] != 3'b000)));
        legal_sel = (size_sel != SIZE_RSVD) && (end_sel <= 33'(MEM_BYTES)) && !misalign;
    end

    // Controller FSM with registered memory-side and response-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            addr_q       <= '0;
            in1_q        <= '0;
            in2_q        <= '0;
            byte_q       <= 1'b0;
            dbl_q        <= 1'b0;
            legal_q      <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_dwrite_q <= 1'b0;
            rsp_valid_q  <= '0;
            rdata_q      <= '0;
            rdata2_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (adv) begin
                        gnt_q        <= gnt;
                        addr_q       <= addr_sel;
                        in1_q        <= wd_sel;
                        in2_q        <= wd2_sel;
                        byte_q       <= (size_sel == SIZE_BYTE);
                        dbl_q        <= (size_sel == SIZE_DOUBLE);
                        legal_q      <= legal_sel;
                        mem_write_q  <= we_sel && legal_sel;
                        mem_dwrite_q <= we_sel && legal_sel && (size_sel == SIZE_DOUBLE);
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_write_q  <= 1'b0;
                    mem_dwrite_q <= 1'b0;
                    if (!legal_q) begin
                        rdata_q <= '0;
                    end else if (byte_q) begin
                        rdata_q <= {24'b0, mem_out1[7:0]};
                    end else begin
                        rdata_q <= mem_out1;
                    end
                    rdata2_q    <= (legal_q && dbl_q) ? mem_out2 : '0;
                    err_q       <= !legal_q;
                    rsp_valid_q <= gnt_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if ((rsp_ready & gnt_q) != '0) begin
                        rsp_valid_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE) ? gnt : '0;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_rdata2  = rdata2_q;
    assign rsp_err     = err_q;
    assign mem_address = addr_q;
    assign mem_in1     = in1_q;
    assign mem_in2     = in2_q;
    assign mem_byte    = byte_q;
    assign mem_write   = mem_write_q;
    assign mem_dwrite  = mem_dwrite_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural big-endian DataMemory.
module tb_dmem_access_ctrl;

    localparam int NREQ = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 load_img = 1'b1;
    logic [NREQ-1:0]      req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [2*NREQ-1:0]    req_size;
    logic [32*NREQ-1:0]   req_addr, req_wdata, req_wdata2;
    logic [31:0]          rsp_rdata, rsp_rdata2;
    logic                 rsp_err;
    logic [31:0]          mem_address, mem_in1, mem_in2, mem_out1, mem_out2;
    logic                 mem_byte, mem_write, mem_dwrite;

    int checks = 0;
    int errors = 0;

    logic [7:0] m [0:1023];
    logic [9:0] ma;

    dmem_access_ctrl #(
        .NREQ         (NREQ),
        .MEM_BYTES    (1024),
        .STRICT_ALIGN (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wdata2  (req_wdata2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_rdata2  (rsp_rdata2),
        .rsp_err     (rsp_err),
        .mem_address (mem_address),
        .mem_in1     (mem_in1),
        .mem_in2     (mem_in2),
        .mem_byte    (mem_byte),
        .mem_write   (mem_write),
        .mem_dwrite  (mem_dwrite),
        .mem_out1    (mem_out1),
        .mem_out2    (mem_out2)
    );

    always #5 clk = ~clk;

    // Combinational read port of the memory model.
    always_comb begin
        ma = mem_address[9:0];
        if (mem_byte) mem_out1 = {24'h0, m[ma]};
        else          mem_out1 = {m[ma], m[ma+10'd1], m[ma+10'd2], m[ma+10'd3]};
        mem_out2 = {m[ma+10'd4], m[ma+10'd5], m[ma+10'd6], m[ma+10'd7]};
    end

    // Reset image load, then level-sensitive writes sampled at the clock edge.
    always @(posedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 1024; i++) m[i] <= 8'h00;
            m[3]  <= 8'h04;
            m[35] <= 8'hD2;
        end else if (mem_write) begin
            if (mem_dwrite) begin
                m[ma]       <= mem_in1[31:24]; m[ma+10'd1] <= mem_in1[23:16];
                m[ma+10'd2] <= mem_in1[15:8];  m[ma+10'd3] <= mem_in1[7:0];
                m[ma+10'd4] <= mem_in2[31:24]; m[ma+10'd5] <= mem_in2[23:16];
                m[ma+10'd6] <= mem_in2[15:8];  m[ma+10'd7] <= mem_in2[7:0];
            end else if (mem_byte) begin
                m[ma] <= mem_in1[7:0];
            end else begin
                m[ma]       <= mem_in1[31:24]; m[ma+10'd1] <= mem_in1[23:16];
                m[ma+10'd2] <= mem_in1[15:8];  m[ma+10'd3] <= mem_in1[7:0];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] wd2);
        req_valid[r]          = 1'b1;
        req_we[r]             = we;
        req_size[2*r +: 2]    = sz;
        req_addr[32*r +: 32]  = a;
        req_wdata[32*r +: 32] = wd;
        req_wdata2[32*r +: 32] = wd2;
    endtask

    // Runs one transaction from an idle controller; lat = -1 if no response.
    task automatic xact(input int r, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] wd2,
                        output logic [31:0] rd, output logic [31:0] rd2, output logic err,
                        output int wr, output int dwr, output int lat);
        drive(r, we, sz, a, wd, wd2);
        wr = 0; dwr = 0; lat = -1; rd = '0; rd2 = '0; err = 1'b0;
        for (int c = 0; c < 10 && lat < 0; c++) begin
            @(negedge clk);
            if (mem_write)  wr++;
            if (mem_dwrite) dwr++;
            if (rsp_valid[r]) begin
                lat = c; rd = rsp_rdata; rd2 = rsp_rdata2; err = rsp_err;
            end
            tick();
            if (c == 0) req_valid[r] = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        load_img = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err} !== '0) begin
            errors++; $display("FAIL reset_handshake got %b%b%b exp 0", req_ready, rsp_valid, rsp_err);
        end
        checks++;
        if ({rsp_rdata, rsp_rdata2} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata got %h %h exp 0", rsp_rdata, rsp_rdata2);
        end
        checks++;
        if ({mem_address, mem_in1, mem_in2, mem_byte, mem_write, mem_dwrite} !== '0) begin
            errors++; $display("FAIL reset_mem got addr %h in1 %h in2 %h b%b w%b d%b exp 0",
                               mem_address, mem_in1, mem_in2, mem_byte, mem_write, mem_dwrite);
        end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_word_load;
        drive(0, 1'b0, 2'b01, 32'd0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL wl_ready got %b exp 01", req_ready);
        end
        tick();
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, mem_write} !== 5'b0) begin
            errors++; $display("FAIL wl_access got rdy %b vld %b wr %b exp 0", req_ready, rsp_valid, mem_write);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_rdata2, rsp_err} !== {2'b01, 32'h4, 32'h0, 1'b0}) begin
            errors++; $display("FAIL wl_resp got vld %b rd %h rd2 %h err %b exp 01 00000004 0 0",
                               rsp_valid, rsp_rdata, rsp_rdata2, rsp_err);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++; $display("FAIL wl_release got %b exp 00", rsp_valid);
        end
        tick();
    endtask

    task automatic test_double;
        logic [31:0] rd, rd2; logic err; int wr, dwr, lat;
        xact(1, 1'b1, 2'b10, 32'd100, 32'h11223344, 32'h55667788, rd, rd2, err, wr, dwr, lat);
        checks++;
        if ({wr, dwr, lat} !== {32'd1, 32'd1, 32'd2} || err !== 1'b0) begin
            errors++; $display("FAIL ds_pulse got wr %0d dwr %0d lat %0d err %b exp 1 1 2 0", wr, dwr, lat, err);
        end
        checks++;
        if ({m[100], m[101], m[102], m[103], m[104], m[105], m[106], m[107]} !== 64'h1122334455667788) begin
            errors++; $display("FAIL ds_mem got %h%h%h%h%h%h%h%h exp 1122334455667788",
                               m[100], m[101], m[102], m[103], m[104], m[105], m[106], m[107]);
        end
        xact(1, 1'b0, 2'b10, 32'd100, 32'h0, 32'h0, rd, rd2, err, wr, dwr, lat);
        checks++;
        if ({rd, rd2, err, wr} !== {32'h11223344, 32'h55667788, 1'b0, 32'd0}) begin
            errors++; $display("FAIL dl_data got %h %h err %b wr %0d exp 11223344 55667788 0 0", rd, rd2, err, wr);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] g [4];
        int t [4];
        int ng = 0;
        logic multi = 1'b0;
        drive(0, 1'b0, 2'b01, 32'd0, 32'h0, 32'h0);
        drive(1, 1'b0, 2'b01, 32'd0, 32'h0, 32'h0);
        for (int c = 0; c < 30 && ng < 4; c++) begin
            @(negedge clk);
            if ($countones(rsp_valid) > 1) multi = 1'b1;
            if (req_ready != 2'b00) begin
                g[ng] = req_ready; t[ng] = c; ng++;
            end
            tick();
        end
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if ($countones(rsp_valid) > 1) multi = 1'b1;
            tick();
        end
        checks++;
        if (ng !== 4) begin
            errors++; $display("FAIL rr_count got %0d exp 4", ng);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (g[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL rr_grant%0d got %b exp %b", k, g[k], (k % 2 == 0) ? 2'b01 : 2'b10);
                end
                if (k > 0) begin
                    checks++;
                    if (t[k] - t[k-1] !== 3) begin
                        errors++; $display("FAIL rr_spacing%0d got %0d exp 3", k, t[k] - t[k-1]);
                    end
                end
            end
        end
        checks++;
        if (multi !== 1'b0) begin
            errors++; $display("FAIL rr_onehot got multiple rsp_valid exp one-hot");
        end
    endtask

    task automatic test_legality;
        logic [31:0] rd, rd2; logic err; int wr, dwr, lat;
        logic [1:0]  tsz [8] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01};
        logic [31:0] tad [8] = '{32'd1020, 32'd1016, 32'd1017, 32'd1023, 32'd1024,
                                  32'hFFFFFFFE, 32'd0, 32'd1};
        logic        ter [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        xact(0, 1'b0, 2'b00, 32'd35, 32'h0, 32'h0, rd, rd2, err, wr, dwr, lat);
        checks++;
        if ({rd, rd2, err} !== {32'h000000D2, 32'h0, 1'b0}) begin
            errors++; $display("FAIL byte_load got %h %h err %b exp 000000d2 0 0", rd, rd2, err);
        end
        xact(0, 1'b1, 2'b01, 32'd1022, 32'hAABBCCDD, 32'h0, rd, rd2, err, wr, dwr, lat);
        checks++;
        if ({err, rd, rd2, wr, lat} !== {1'b1, 32'h0, 32'h0, 32'd0, 32'd2}) begin
            errors++; $display("FAIL oor_store got err %b rd %h rd2 %h wr %0d lat %0d exp 1 0 0 0 2",
                               err, rd, rd2, wr, lat);
        end
        checks++;
        if ({m[1022], m[1023]} !== 16'h0000) begin
            errors++; $display("FAIL oor_mem got %h%h exp 0000", m[1022], m[1023]);
        end
        for (int k = 0; k < 8; k++) begin
            xact(k % 2, 1'b0, tsz[k], tad[k], 32'h0, 32'h0, rd, rd2, err, wr, dwr, lat);
            checks++;
            if (err !== ter[k] || lat !== 2 || (ter[k] && {rd, rd2} !== 64'h0)) begin
                errors++; $display("FAIL legal%0d size %b addr %h got err %b lat %0d rd %h exp err %b",
                                   k, tsz[k], tad[k], err, lat, rd, ter[k]);
            end
        end
    endtask

    task automatic test_stall;
        rsp_ready = 2'b00;
        drive(1, 1'b0, 2'b01, 32'd0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL st_grant got %b exp 10", req_ready);
        end
        tick();
        req_valid[1] = 1'b0;
        drive(0, 1'b0, 2'b00, 32'd35, 32'h0, 32'h0);
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_rdata, rsp_rdata2, req_ready} !== {2'b10, 32'h4, 32'h0, 2'b00}) begin
                errors++; $display("FAIL st_hold%0d got vld %b rd %h rd2 %h rdy %b exp 10 00000004 0 00",
                                   k, rsp_valid, rsp_rdata, rsp_rdata2, req_ready);
            end
            tick();
        end
        rsp_ready = '1;
        tick();
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid} !== {2'b01, 2'b00}) begin
            errors++; $display("FAIL st_release got rdy %b vld %b exp 01 00", req_ready, rsp_valid);
        end
        tick();
        req_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_access;
        drive(0, 1'b1, 2'b01, 32'd200, 32'hDEADBEEF, 32'h0);
        tick();
        req_valid = '0;
        checks++;
        if ({mem_write, mem_address, mem_in1} !== {1'b1, 32'd200, 32'hDEADBEEF}) begin
            errors++; $display("FAIL ra_access got wr %b addr %h in1 %h exp 1 000000c8 deadbeef",
                               mem_write, mem_address, mem_in1);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({mem_write, mem_dwrite, mem_byte, mem_address, mem_in1, mem_in2} !== '0) begin
            errors++; $display("FAIL ra_mem_clear got wr %b addr %h in1 %h exp 0", mem_write, mem_address, mem_in1);
        end
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, rsp_rdata2} !== '0) begin
            errors++; $display("FAIL ra_rsp_clear got rdy %b vld %b err %b rd %h exp 0",
                               req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        checks++;
        if ({m[200], m[201], m[202], m[203]} !== 32'h0) begin
            errors++; $display("FAIL ra_mem_unchanged got %h%h%h%h exp 00000000", m[200], m[201], m[202], m[203]);
        end
        drive(0, 1'b0, 2'b01, 32'd0, 32'h0, 32'h0);
        drive(1, 1'b0, 2'b01, 32'd0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL ra_first_grant got %b exp 01", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (3) tick();
    endtask

    initial begin
        req_valid  = '0;
        req_we     = '0;
        req_size   = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_wdata2 = '0;
        rsp_ready  = '1;
        test_reset();
        test_word_load();
        test_double();
        test_round_robin();
        test_legality();
        test_stall();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
